// File: rtl/hyper_write_dq_serializer_if.sv
// hyper_write_dq_serializer_if
// Purpose : TX write-data stream (valid/ready) feeding the HyperBus DQ serializer.
// Signals : valid_i  word valid (source -> serializer)
//           data_i   32-bit write word
//           strb_i   byte enables, 1 = write byte
//           ready_o  serializer accepts the word this cycle
// Modports: master = stream source, slave = serializer.
interface hyper_write_dq_serializer_if;
    logic        valid_i;
    logic [31:0] data_i;
    logic [3:0]  strb_i;
    logic        ready_o;

    modport master (
        output valid_i,
        output data_i,
        output strb_i,
        input  ready_o
    );

    modport slave (
        input  valid_i,
        input  data_i,
        input  strb_i,
        output ready_o
    );
endinterface

// File: rtl/hyper_write_dq_serializer.sv
// hyper_write_dq_serializer
// Purpose : transmit-side HyperBus PHY data path. Turns 32-bit TX words into one
//           DDR beat per clk0 cycle (registered rise/fall halves), drives the
//           RWDS write mask, the DQ/RWDS output enables and the CK gate enable.
//           On stream underrun CK is gated off rather than sending stale data.
// Ports   : clk0        PHY clock, one beat per cycle
//           rst_i       asynchronous reset, active-high
//           mem_sel_i   2'b11 = dual x8 (x16 bus), else single x8; latched at start
//           start_i     start a write burst (IDLE only)
//           len_i       burst length in beats, latched with start_i
//           abort_i     terminate the burst immediately
//           tx          TX word stream (slave side)
//           dq_rise_o / dq_fall_o      DQ for CK rising / falling edge
//           rwds_rise_o / rwds_fall_o  RWDS mask halves (1 = byte masked)
//           dq_oe_o / rwds_oe_o        output enables
//           clk_en_o    CK gate enable for this cycle's beat
//           busy_o      burst in progress
//           done_o      one-cycle pulse on normal completion
module hyper_write_dq_serializer #(
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                 clk0,
    input  logic                 rst_i,
    input  logic [1:0]           mem_sel_i,
    input  logic                 start_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    input  logic                 abort_i,
    hyper_write_dq_serializer_if.slave tx,
    output logic [15:0]          dq_rise_o,
    output logic [15:0]          dq_fall_o,
    output logic [1:0]           rwds_rise_o,
    output logic [1:0]           rwds_fall_o,
    output logic                 dq_oe_o,
    output logic                 rwds_oe_o,
    output logic                 clk_en_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned DQ_W   = 16;
    localparam int unsigned RWDS_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        LAST   = 2'd2
    } state_t;

    state_t               state_q;
    logic                 x16_q;
    logic [LEN_WIDTH-1:0] cnt_q;

    logic                 hs_c;
    logic [DQ_W-1:0]      beat_rise_c;
    logic [DQ_W-1:0]      beat_fall_c;
    logic [RWDS_W-1:0]    mask_rise_c;
    logic [RWDS_W-1:0]    mask_fall_c;

    // Ready only while beats remain, so the counter can never underflow.
    assign tx.ready_o = (state_q == ACTIVE) && (cnt_q != '0) && !abort_i;
    assign hs_c       = tx.valid_i && tx.ready_o;
    assign busy_o     = (state_q != IDLE);

    // Word-to-beat lane mapping; x8 drives only the low byte lane.
    always_comb begin
        beat_rise_c = '0;
        beat_fall_c = '0;
        mask_rise_c = '0;
        mask_fall_c = '0;
        if (x16_q) begin
            beat_rise_c = tx.data_i[31:16];
            beat_fall_c = tx.data_i[15:0];
            mask_rise_c = ~tx.strb_i[3:2];
            mask_fall_c = ~tx.strb_i[1:0];
        end else begin
            beat_rise_c = {8'h00, tx.data_i[15:8]};
            beat_fall_c = {8'h00, tx.data_i[7:0]};
            mask_rise_c = {1'b0, ~tx.strb_i[1]};
            mask_fall_c = {1'b0, ~tx.strb_i[0]};
        end
    end

    // Burst control and registered beat outputs.
    always_ff @(posedge clk0 or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            x16_q       <= 1'b0;
            cnt_q       <= '0;
            dq_rise_o   <= '0;
            dq_fall_o   <= '0;
            rwds_rise_o <= '0;
            rwds_fall_o <= '0;
            dq_oe_o     <= 1'b0;
            rwds_oe_o   <= 1'b0;
            clk_en_o    <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    clk_en_o  <= 1'b0;
                    dq_oe_o   <= 1'b0;
                    rwds_oe_o <= 1'b0;
                    if (start_i && !abort_i) begin
                        if (len_i == '0) begin
                            // Empty burst completes without any beats.
                            done_o <= 1'b1;
                        end else begin
                            x16_q   <= (mem_sel_i == 2'b11);
                            cnt_q   <= len_i;
                            state_q <= ACTIVE;
                        end
                    end
                end

                ACTIVE: begin
                    if (abort_i) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        clk_en_o  <= 1'b0;
                        dq_oe_o   <= 1'b0;
                        rwds_oe_o <= 1'b0;
                    end else if (hs_c) begin
                        dq_rise_o   <= beat_rise_c;
                        dq_fall_o   <= beat_fall_c;
                        rwds_rise_o <= mask_rise_c;
                        rwds_fall_o <= mask_fall_c;
                        clk_en_o    <= 1'b1;
                        dq_oe_o     <= 1'b1;
                        rwds_oe_o   <= 1'b1;
                        cnt_q       <= cnt_q - LEN_WIDTH'(1);
                        if (cnt_q == LEN_WIDTH'(1)) begin
                            state_q <= LAST;
                        end
                    end else begin
                        // Underrun: gate CK, hold the last beat and enables.
                        clk_en_o <= 1'b0;
                    end
                end

                LAST: begin
                    // Final beat is on the pins this cycle; close the burst.
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    clk_en_o  <= 1'b0;
                    dq_oe_o   <= 1'b0;
                    rwds_oe_o <= 1'b0;
                    done_o    <= !abort_i;
                end

                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    clk_en_o  <= 1'b0;
                    dq_oe_o   <= 1'b0;
                    rwds_oe_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
